// File: rtl/ibex_rf_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// It defines the register address width, the write-source grant encoding
// and a small helper that tests for a non-x0 register address.
package ibex_rf_wr_arbiter_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegDataW = 32;
  localparam int unsigned NumRegs  = 32;

  // Internal grant select for the register-file write mux.
  typedef enum logic [1:0] {
    RF_WR_SRC_NONE = 2'd0,
    RF_WR_SRC_LSU  = 2'd1,
    RF_WR_SRC_ACC  = 2'd2,
    RF_WR_SRC_CORE = 2'd3
  } rf_wr_src_e;

  // x0 is hard-wired to zero, so it never participates in hazard tracking.
  function automatic logic reg_nz(input logic [RegAddrW-1:0] addr);
    return addr != {RegAddrW{1'b0}};
  endfunction

endpackage

// File: rtl/ibex_rf_wr_arbiter_if.sv
// Bundle of the LSU, core, accelerator, ID-stage and register-file signals
// around the write arbiter. The slave modport is the arbiter's view and the
// master modport is the view of the surrounding pipeline.
interface ibex_rf_wr_arbiter_if
  import ibex_rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned CntW = 3
);

  logic                lsu_we_i;
  logic [RegAddrW-1:0] lsu_waddr_i;
  logic [RegDataW-1:0] lsu_wdata_i;

  logic                core_we_i;
  logic [RegAddrW-1:0] core_waddr_i;
  logic [RegDataW-1:0] core_wdata_i;
  logic                core_ready_o;

  logic                acc_issue_i;
  logic [RegAddrW-1:0] acc_issue_rd_i;
  logic                acc_issue_ready_o;

  logic                acc_valid_i;
  logic [RegAddrW-1:0] acc_waddr_i;
  logic [RegDataW-1:0] acc_wdata_i;
  logic                acc_ready_o;

  logic [RegAddrW-1:0] rs1_addr_i;
  logic [RegAddrW-1:0] rs2_addr_i;
  logic                rs_hazard_o;

  logic                rf_we_o;
  logic [RegAddrW-1:0] rf_waddr_o;
  logic [RegDataW-1:0] rf_wdata_o;

  logic [CntW-1:0]     acc_outstanding_o;
  logic                acc_err_o;

  modport slave (
    input  lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    input  core_we_i, core_waddr_i, core_wdata_i,
    output core_ready_o,
    input  acc_issue_i, acc_issue_rd_i,
    output acc_issue_ready_o,
    input  acc_valid_i, acc_waddr_i, acc_wdata_i,
    output acc_ready_o,
    input  rs1_addr_i, rs2_addr_i,
    output rs_hazard_o,
    output rf_we_o, rf_waddr_o, rf_wdata_o,
    output acc_outstanding_o, acc_err_o
  );

  modport master (
    output lsu_we_i, lsu_waddr_i, lsu_wdata_i,
    output core_we_i, core_waddr_i, core_wdata_i,
    input  core_ready_o,
    output acc_issue_i, acc_issue_rd_i,
    input  acc_issue_ready_o,
    output acc_valid_i, acc_waddr_i, acc_wdata_i,
    input  acc_ready_o,
    output rs1_addr_i, rs2_addr_i,
    input  rs_hazard_o,
    input  rf_we_o, rf_waddr_o, rf_wdata_o,
    input  acc_outstanding_o, acc_err_o
  );

endinterface

// File: rtl/ibex_rf_scoreboard.sv
// Tracks destination registers still owed by the decoupled accelerator.
// Holds the pending-register bitmap and the outstanding-op counter, gates new
// dispatches, answers hazard lookups and raises a sticky protocol error.
module ibex_rf_scoreboard
  import ibex_rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // dispatch request and its acceptance
  input  logic                issue_i,
  input  logic [RegAddrW-1:0] issue_rd_i,
  output logic                issue_ready_o,
  // completed retire handshake
  input  logic                retire_i,
  input  logic [RegAddrW-1:0] retire_rd_i,
  // LSU write, checked against pending registers
  input  logic                lsu_we_i,
  input  logic [RegAddrW-1:0] lsu_waddr_i,
  // lookups
  input  logic [RegAddrW-1:0] core_waddr_i,
  output logic                core_pend_o,
  input  logic [RegAddrW-1:0] rs1_addr_i,
  input  logic [RegAddrW-1:0] rs2_addr_i,
  output logic                rs_hazard_o,
  // status
  output logic [CntW-1:0]     cnt_o,
  output logic                err_o
);

  logic [NumRegs-1:0] sb_q, sb_d;
  logic [NumRegs-1:0] set_mask, clr_mask;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               acc_err_q, acc_err_d;
  logic               issue_hs;
  logic               err_underflow, err_stray_retire, err_lsu_clobber;

  // A dispatch is refused when credits run out or its rd is still owed.
  assign issue_ready_o = (cnt_q < CntW'(MaxOutstanding)) &
                         (~reg_nz(issue_rd_i) | ~sb_q[issue_rd_i]);
  assign issue_hs      = issue_i & issue_ready_o;

  assign core_pend_o = reg_nz(core_waddr_i) & sb_q[core_waddr_i];
  assign rs_hazard_o = (reg_nz(rs1_addr_i) & sb_q[rs1_addr_i]) |
                       (reg_nz(rs2_addr_i) & sb_q[rs2_addr_i]);

  // Bitmap update: an rd=x0 dispatch sets nothing and bit 0 is kept clear.
  always_comb begin
    set_mask = (issue_hs & reg_nz(issue_rd_i)) ? (32'b1 << issue_rd_i) : 32'b0;
    clr_mask = retire_i ? (32'b1 << retire_rd_i) : 32'b0;
    sb_d     = (sb_q | set_mask) & ~clr_mask & ~32'b1;
  end

  // Credit counter: simultaneous issue and retire cancel; never underflows.
  always_comb begin
    cnt_d = cnt_q;
    case ({issue_hs, retire_i})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = (cnt_q == {CntW{1'b0}}) ? cnt_q : cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Sticky protocol error from stray retires and LSU writes to owed registers.
  always_comb begin
    err_underflow    = retire_i & (cnt_q == {CntW{1'b0}});
    err_stray_retire = retire_i & reg_nz(retire_rd_i) & ~sb_q[retire_rd_i];
    err_lsu_clobber  = lsu_we_i & reg_nz(lsu_waddr_i) & sb_q[lsu_waddr_i];
    acc_err_d        = acc_err_q | err_underflow | err_stray_retire | err_lsu_clobber;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q      <= 32'b0;
      cnt_q     <= {CntW{1'b0}};
      acc_err_q <= 1'b0;
    end else begin
      sb_q      <= sb_d;
      cnt_q     <= cnt_d;
      acc_err_q <= acc_err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = acc_err_q;

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter between LSU load data, core writeback and
// out-of-order accelerator results. Priority is LSU > starved accelerator >
// core > accelerator; the write happens in the cycle of the handshake.
module ibex_rf_wr_arbiter
  import ibex_rf_wr_arbiter_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AccStarveLimit = 8,
  parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  ibex_rf_wr_arbiter_if.slave bus
);

  localparam int unsigned StvW = 8;

  logic [StvW-1:0] stv_q, stv_d;
  logic            starved;
  logic            core_pend;
  logic            waw_core;
  logic            core_ready;
  logic            acc_ready;
  logic            core_hs;
  logic            acc_hs;
  rf_wr_src_e      grant;

  ibex_rf_scoreboard #(
    .MaxOutstanding (MaxOutstanding),
    .CntW           (CntW)
  ) u_scoreboard (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .issue_i        (bus.acc_issue_i),
    .issue_rd_i     (bus.acc_issue_rd_i),
    .issue_ready_o  (bus.acc_issue_ready_o),
    .retire_i       (acc_hs),
    .retire_rd_i    (bus.acc_waddr_i),
    .lsu_we_i       (bus.lsu_we_i),
    .lsu_waddr_i    (bus.lsu_waddr_i),
    .core_waddr_i   (bus.core_waddr_i),
    .core_pend_o    (core_pend),
    .rs1_addr_i     (bus.rs1_addr_i),
    .rs2_addr_i     (bus.rs2_addr_i),
    .rs_hazard_o    (bus.rs_hazard_o),
    .cnt_o          (bus.acc_outstanding_o),
    .err_o          (bus.acc_err_o)
  );

  // A core write to a register still owed by the accelerator must wait for
  // that result, otherwise the late accelerator write would overwrite it.
  assign starved    = (stv_q == StvW'(AccStarveLimit));
  assign waw_core   = bus.core_we_i & core_pend;
  assign core_ready = ~bus.lsu_we_i & ~(starved & bus.acc_valid_i) & ~waw_core;
  assign acc_ready  = ~bus.lsu_we_i & (starved | ~bus.core_we_i | waw_core);
  assign core_hs    = bus.core_we_i & core_ready;
  assign acc_hs     = bus.acc_valid_i & acc_ready;

  assign bus.core_ready_o = core_ready;
  assign bus.acc_ready_o  = acc_ready;

  // Pick the single source that owns the write port this cycle.
  always_comb begin
    grant = RF_WR_SRC_NONE;
    if (bus.lsu_we_i) begin
      grant = RF_WR_SRC_LSU;
    end else if (acc_hs && starved) begin
      grant = RF_WR_SRC_ACC;
    end else if (core_hs) begin
      grant = RF_WR_SRC_CORE;
    end else if (acc_hs) begin
      grant = RF_WR_SRC_ACC;
    end else begin
      grant = RF_WR_SRC_NONE;
    end
  end

  // Write-port mux driven by the grant.
  always_comb begin
    bus.rf_we_o    = 1'b0;
    bus.rf_waddr_o = {RegAddrW{1'b0}};
    bus.rf_wdata_o = {RegDataW{1'b0}};
    case (grant)
      RF_WR_SRC_LSU: begin
        bus.rf_we_o    = 1'b1;
        bus.rf_waddr_o = bus.lsu_waddr_i;
        bus.rf_wdata_o = bus.lsu_wdata_i;
      end
      RF_WR_SRC_CORE: begin
        bus.rf_we_o    = 1'b1;
        bus.rf_waddr_o = bus.core_waddr_i;
        bus.rf_wdata_o = bus.core_wdata_i;
      end
      RF_WR_SRC_ACC: begin
        bus.rf_we_o    = 1'b1;
        bus.rf_waddr_o = bus.acc_waddr_i;
        bus.rf_wdata_o = bus.acc_wdata_i;
      end
      default: begin
        bus.rf_we_o    = 1'b0;
        bus.rf_waddr_o = {RegAddrW{1'b0}};
        bus.rf_wdata_o = {RegDataW{1'b0}};
      end
    endcase
  end

  // Count consecutive refused accelerator results, saturating at the limit.
  always_comb begin
    stv_d = stv_q;
    if (bus.acc_valid_i && !acc_ready) begin
      stv_d = starved ? stv_q : stv_q + StvW'(1);
    end else begin
      stv_d = {StvW{1'b0}};
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stv_q <= {StvW{1'b0}};
    end else begin
      stv_q <= stv_d;
    end
  end

endmodule

// File: tb/tb_ibex_rf_wr_arbiter.sv
// Self-checking bench for the register-file write arbiter: directed scenarios
// followed by constrained-random traffic, all compared every cycle against a
// behavioural model of owed registers, credits and starvation.
module tb_ibex_rf_wr_arbiter;
  import ibex_rf_wr_arbiter_pkg::*;

  localparam int MAX   = 4;
  localparam int LIMIT = 8;
  localparam int CW    = $clog2(MAX + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_rf_wr_arbiter_if #(.CntW(CW)) bus();

  ibex_rf_wr_arbiter #(
    .MaxOutstanding (MAX),
    .AccStarveLimit (LIMIT)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  bit pend[32];
  int m_cnt;
  int m_x0;
  int m_stv;
  bit m_err;
  bit last_core_hs;
  bit last_acc_hs;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.lsu_we_i       = 1'b0; bus.lsu_waddr_i  = 5'd0; bus.lsu_wdata_i  = 32'd0;
    bus.core_we_i      = 1'b0; bus.core_waddr_i = 5'd0; bus.core_wdata_i = 32'd0;
    bus.acc_issue_i    = 1'b0; bus.acc_issue_rd_i = 5'd0;
    bus.acc_valid_i    = 1'b0; bus.acc_waddr_i  = 5'd0; bus.acc_wdata_i  = 32'd0;
    bus.rs1_addr_i     = 5'd0; bus.rs2_addr_i   = 5'd0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 1'b0;
    m_cnt = 0; m_x0 = 0; m_stv = 0; m_err = 1'b0;
    last_core_hs = 1'b0; last_acc_hs = 1'b0;
  endtask

  // Called right after a negedge with inputs applied: checks this cycle's
  // outputs against the model, then advances the model to the next cycle.
  task automatic sample();
    bit starved, waw, e_cr, e_ar, e_ir, e_hz, core_hs, acc_hs, iss_hs;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit e_we;
    #1;
    starved = (m_stv == LIMIT);
    waw     = bus.core_we_i && bus.core_waddr_i != 5'd0 && pend[bus.core_waddr_i];
    e_cr    = !bus.lsu_we_i && !(starved && bus.acc_valid_i) && !waw;
    e_ar    = !bus.lsu_we_i && (starved || !bus.core_we_i || waw);
    e_ir    = (m_cnt < MAX) && (bus.acc_issue_rd_i == 5'd0 || !pend[bus.acc_issue_rd_i]);
    e_hz    = (bus.rs1_addr_i != 5'd0 && pend[bus.rs1_addr_i]) ||
              (bus.rs2_addr_i != 5'd0 && pend[bus.rs2_addr_i]);
    core_hs = bus.core_we_i && e_cr;
    acc_hs  = bus.acc_valid_i && e_ar;
    iss_hs  = bus.acc_issue_i && e_ir;
    e_we    = bus.lsu_we_i || core_hs || acc_hs;
    if (bus.lsu_we_i)  begin e_addr = bus.lsu_waddr_i;  e_data = bus.lsu_wdata_i;  end
    else if (core_hs)  begin e_addr = bus.core_waddr_i; e_data = bus.core_wdata_i; end
    else               begin e_addr = bus.acc_waddr_i;  e_data = bus.acc_wdata_i;  end

    check_val("core_ready", {31'd0, bus.core_ready_o}, {31'd0, e_cr});
    check_val("acc_ready", {31'd0, bus.acc_ready_o}, {31'd0, e_ar});
    check_val("issue_ready", {31'd0, bus.acc_issue_ready_o}, {31'd0, e_ir});
    check_val("rs_hazard", {31'd0, bus.rs_hazard_o}, {31'd0, e_hz});
    check_val("outstanding", 32'(bus.acc_outstanding_o), 32'(m_cnt));
    check_val("acc_err", {31'd0, bus.acc_err_o}, {31'd0, m_err});
    check_val("rf_we", {31'd0, bus.rf_we_o}, {31'd0, e_we});
    if (e_we) begin
      check_val("rf_waddr", {27'd0, bus.rf_waddr_o}, {27'd0, e_addr});
      check_val("rf_wdata", bus.rf_wdata_o, e_data);
    end

    // next-state of the model
    if (acc_hs) begin
      if (m_cnt == 0) m_err = 1'b1;
      if (bus.acc_waddr_i != 5'd0 && !pend[bus.acc_waddr_i]) m_err = 1'b1;
    end
    if (bus.lsu_we_i && bus.lsu_waddr_i != 5'd0 && pend[bus.lsu_waddr_i]) m_err = 1'b1;
    if (acc_hs) begin
      pend[bus.acc_waddr_i] = 1'b0;
      if (bus.acc_waddr_i == 5'd0 && m_x0 > 0) m_x0--;
    end
    if (iss_hs) begin
      if (bus.acc_issue_rd_i != 5'd0) pend[bus.acc_issue_rd_i] = 1'b1;
      else m_x0++;
    end
    if (iss_hs && !acc_hs) m_cnt++;
    else if (acc_hs && !iss_hs && m_cnt > 0) m_cnt--;
    if (bus.acc_valid_i && !e_ar) m_stv = (m_stv < LIMIT) ? m_stv + 1 : LIMIT;
    else m_stv = 0;
    last_core_hs = core_hs;
    last_acc_hs  = acc_hs;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    idle();
    model_reset();
    @(negedge clk);
    do_reset();

    // reset values and idle period
    sample();
    check_val("rst_core_ready", {31'd0, bus.core_ready_o}, 32'd1);
    check_val("rst_acc_ready", {31'd0, bus.acc_ready_o}, 32'd1);
    check_val("rst_issue_ready", {31'd0, bus.acc_issue_ready_o}, 32'd1);
    check_val("rst_outstanding", 32'(bus.acc_outstanding_o), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      sample();
      check_val("idle_rf_we", {31'd0, bus.rf_we_o}, 32'd0);
      @(negedge clk);
    end

    // LSU beats core, core writes next cycle
    bus.lsu_we_i = 1'b1; bus.lsu_waddr_i = 5'd5; bus.lsu_wdata_i = 32'hAAAA_0000;
    bus.core_we_i = 1'b1; bus.core_waddr_i = 5'd6; bus.core_wdata_i = 32'h0000_1234;
    sample();
    check_val("lsu_win_addr", {27'd0, bus.rf_waddr_o}, 32'd5);
    check_val("lsu_win_data", bus.rf_wdata_o, 32'hAAAA_0000);
    check_val("lsu_win_core_stall", {31'd0, bus.core_ready_o}, 32'd0);
    @(negedge clk);
    bus.lsu_we_i = 1'b0;
    sample();
    check_val("core_after_addr", {27'd0, bus.rf_waddr_o}, 32'd6);
    check_val("core_after_data", bus.rf_wdata_o, 32'h0000_1234);
    check_val("core_after_ready", {31'd0, bus.core_ready_o}, 32'd1);
    @(negedge clk);
    idle();

    // issue x7, hazard + WAW stall, retire
    bus.acc_issue_i = 1'b1; bus.acc_issue_rd_i = 5'd7;
    sample();
    @(negedge clk);
    idle();
    bus.rs1_addr_i = 5'd7;
    bus.core_we_i = 1'b1; bus.core_waddr_i = 5'd7; bus.core_wdata_i = 32'h77;
    sample();
    check_val("x7_hazard", {31'd0, bus.rs_hazard_o}, 32'd1);
    check_val("x7_outstanding", 32'(bus.acc_outstanding_o), 32'd1);
    check_val("x7_waw_stall", {31'd0, bus.core_ready_o}, 32'd0);
    @(negedge clk);
    bus.core_we_i = 1'b0;
    bus.acc_valid_i = 1'b1; bus.acc_waddr_i = 5'd7; bus.acc_wdata_i = 32'h55;
    sample();
    check_val("x7_ret_addr", {27'd0, bus.rf_waddr_o}, 32'd7);
    check_val("x7_ret_data", bus.rf_wdata_o, 32'h55);
    check_val("x7_ret_hazard_same", {31'd0, bus.rs_hazard_o}, 32'd1);
    @(negedge clk);
    idle();
    bus.rs1_addr_i = 5'd7;
    sample();
    check_val("x7_hazard_clear", {31'd0, bus.rs_hazard_o}, 32'd0);
    check_val("x7_count_zero", 32'(bus.acc_outstanding_o), 32'd0);
    @(negedge clk);
    idle();

    // fill the credits, then refuse the fifth dispatch
    for (int i = 1; i <= 4; i++) begin
      bus.acc_issue_i = 1'b1; bus.acc_issue_rd_i = 5'(i);
      sample();
      @(negedge clk);
    end
    bus.acc_issue_i = 1'b1; bus.acc_issue_rd_i = 5'd5;
    sample();
    check_val("full_issue_refused", {31'd0, bus.acc_issue_ready_o}, 32'd0);
    check_val("full_count", 32'(bus.acc_outstanding_o), 32'd4);
    @(negedge clk);
    // at full: retire x1 while dispatch is refused
    bus.acc_valid_i = 1'b1; bus.acc_waddr_i = 5'd1; bus.acc_wdata_i = 32'h11;
    sample();
    check_val("full_iss_ret_refused", {31'd0, bus.acc_issue_ready_o}, 32'd0);
    @(negedge clk);
    // issue x6 with retire x2 in the same cycle: count unchanged
    bus.acc_issue_rd_i = 5'd6; bus.acc_waddr_i = 5'd2; bus.acc_wdata_i = 32'h22;
    sample();
    check_val("iss_ret_ready", {31'd0, bus.acc_issue_ready_o}, 32'd1);
    @(negedge clk);
    idle();
    sample();
    check_val("iss_ret_count", 32'(bus.acc_outstanding_o), 32'd3);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.acc_valid_i = 1'b1;
      bus.acc_waddr_i = (i == 0) ? 5'd3 : (i == 1) ? 5'd4 : 5'd6;
      sample();
      @(negedge clk);
    end
    idle();

    // starvation: core hogs the port, accelerator pre-empts after the limit
    bus.acc_issue_i = 1'b1; bus.acc_issue_rd_i = 5'd11;
    sample();
    @(negedge clk);
    idle();
    bus.core_we_i = 1'b1; bus.core_waddr_i = 5'd10; bus.core_wdata_i = 32'hC0DE;
    bus.acc_valid_i = 1'b1; bus.acc_waddr_i = 5'd11; bus.acc_wdata_i = 32'hBEEF;
    for (int i = 0; i < LIMIT; i++) begin
      sample();
      check_val("starve_acc_refused", {31'd0, bus.acc_ready_o}, 32'd0);
      check_val("starve_core_ok", {31'd0, bus.core_ready_o}, 32'd1);
      @(negedge clk);
    end
    sample();
    check_val("starve_acc_wins", {31'd0, bus.acc_ready_o}, 32'd1);
    check_val("starve_core_held", {31'd0, bus.core_ready_o}, 32'd0);
    check_val("starve_addr", {27'd0, bus.rf_waddr_o}, 32'd11);
    @(negedge clk);
    bus.acc_valid_i = 1'b0;
    sample();
    @(negedge clk);
    idle();

    // stray retire raises a sticky error until reset
    bus.acc_valid_i = 1'b1; bus.acc_waddr_i = 5'd9; bus.acc_wdata_i = 32'h99;
    sample();
    @(negedge clk);
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.lsu_we_i = 1'b1; bus.lsu_waddr_i = 5'(12 + i); bus.lsu_wdata_i = 32'(i);
      sample();
      check_val("err_sticky", {31'd0, bus.acc_err_o}, 32'd1);
      @(negedge clk);
    end
    do_reset();
    sample();
    check_val("err_cleared", {31'd0, bus.acc_err_o}, 32'd0);
    @(negedge clk);

    // constrained-random traffic with periodic mid-run resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 1000 == 999) do_reset();
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 31);
        if (r != 0 && pend[r] && $urandom_range(0, 63) != 0) r = 0;
        bus.lsu_we_i = 1'b1; bus.lsu_waddr_i = 5'(r); bus.lsu_wdata_i = $urandom;
      end else begin
        bus.lsu_we_i = 1'b0;
      end
      if (!bus.core_we_i || last_core_hs) begin
        bus.core_we_i    = 1'($urandom_range(0, 1));
        bus.core_waddr_i = 5'($urandom_range(0, 31));
        bus.core_wdata_i = $urandom;
      end
      if (!bus.acc_valid_i || last_acc_hs) begin
        bus.acc_valid_i = 1'b0;
        r = $urandom_range(0, 31);
        if ($urandom_range(0, 2) == 0 &&
            ((r == 0 && m_x0 > 0) || (r != 0 && pend[r]) || $urandom_range(0, 199) == 0)) begin
          bus.acc_valid_i = 1'b1; bus.acc_waddr_i = 5'(r); bus.acc_wdata_i = $urandom;
        end
      end
      bus.acc_issue_i    = ($urandom_range(0, 2) == 0);
      bus.acc_issue_rd_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      bus.rs1_addr_i     = 5'($urandom_range(0, 31));
      bus.rs2_addr_i     = 5'($urandom_range(0, 31));
      sample();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
